// File: rtl/upe_pipeadd.sv
// Pipelined three-operand adder: Out = A + B +/- C, two independent carry chains,
// one SLICE-bit carry-propagate stage per pipeline stage, valid/ready handshake.
module upe_pipeadd #(
    parameter int WIDTH  = 64,
    parameter int SLICE  = 32,
    parameter int SIGNED = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic             sub,
    input  logic             carryin1,
    input  logic             carryin2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             carryout1,
    output logic             carryout2,
    output logic             ovf1,
    output logic             ovf2
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int LAST   = NSLICE - 1;

    // Handshake: a transaction is accepted on a rising edge with in_valid & in_ready and
    // delivered on a rising edge with out_valid & out_ready. Every stage advances together
    // on en = !out_valid | out_ready; with en low all stages (bubbles included) hold, so
    // Out and the flags stay stable until the consumer takes them.
    logic en;

    // Stage k registers; stage k feeds stage k+1, the last one drives the outputs.
    logic             vld_q [NSLICE];
    logic             sub_q [NSLICE];
    logic             c1_q  [NSLICE];
    logic             c2_q  [NSLICE];
    logic [WIDTH-1:0] res_q [NSLICE];
    logic [WIDTH-1:0] a_q   [NSLICE];
    logic [WIDTH-1:0] b_q   [NSLICE];
    logic [WIDTH-1:0] c_q   [NSLICE];
    logic             ovf1_q;
    logic             ovf2_q;

    // Stage k inputs: ports for stage 0, previous stage registers otherwise.
    logic             st_vld [NSLICE];
    logic             st_sub [NSLICE];
    logic             st_c1  [NSLICE];
    logic             st_c2  [NSLICE];
    logic [WIDTH-1:0] st_res [NSLICE];
    logic [WIDTH-1:0] st_a   [NSLICE];
    logic [WIDTH-1:0] st_b   [NSLICE];
    logic [WIDTH-1:0] st_c   [NSLICE];

    logic [SLICE-1:0] cs_w    [NSLICE];
    logic [SLICE:0]   s1_w    [NSLICE];
    logic [SLICE:0]   s2_w    [NSLICE];
    logic [WIDTH-1:0] nxt_res [NSLICE];
    logic             o1_w;
    logic             o2_w;

    assign out_valid = vld_q[LAST];
    assign en        = !out_valid | out_ready;
    assign in_ready  = en;

    always_comb begin
        st_vld[0] = in_valid;
        st_sub[0] = sub;
        st_c1[0]  = carryin1;
        // Subtraction adds ~C with an inverted borrow-in, so carryin2 flips with sub.
        st_c2[0]  = carryin2 ^ sub;
        st_res[0] = '0;
        st_a[0]   = A;
        st_b[0]   = B;
        st_c[0]   = C;
        for (int k = 1; k < NSLICE; k++) begin
            st_vld[k] = vld_q[k-1];
            st_sub[k] = sub_q[k-1];
            st_c1[k]  = c1_q[k-1];
            st_c2[k]  = c2_q[k-1];
            st_res[k] = res_q[k-1];
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_c[k]   = c_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < NSLICE; k++) begin
            cs_w[k] = st_c[k][k*SLICE +: SLICE] ^ {SLICE{st_sub[k]}};
            s1_w[k] = {1'b0, st_a[k][k*SLICE +: SLICE]} + {1'b0, st_b[k][k*SLICE +: SLICE]}
                    + {{SLICE{1'b0}}, st_c1[k]};
            s2_w[k] = {1'b0, s1_w[k][SLICE-1:0]} + {1'b0, cs_w[k]} + {{SLICE{1'b0}}, st_c2[k]};
            nxt_res[k] = st_res[k];
            nxt_res[k][k*SLICE +: SLICE] = s2_w[k][SLICE-1:0];
        end
        // Carry into the MSB equals a_msb ^ b_msb ^ sum_msb, so this is cin_msb ^ cout.
        o1_w = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1] ^ s1_w[LAST][SLICE-1] ^ s1_w[LAST][SLICE];
        o2_w = s1_w[LAST][SLICE-1] ^ cs_w[LAST][SLICE-1] ^ s2_w[LAST][SLICE-1] ^ s2_w[LAST][SLICE];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < NSLICE; k++) begin
                vld_q[k] <= 1'b0;
                sub_q[k] <= 1'b0;
                c1_q[k]  <= 1'b0;
                c2_q[k]  <= 1'b0;
                res_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= '0;
            end
            ovf1_q <= 1'b0;
            ovf2_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NSLICE; k++) begin
                vld_q[k] <= st_vld[k];
                sub_q[k] <= st_sub[k];
                c1_q[k]  <= s1_w[k][SLICE];
                c2_q[k]  <= s2_w[k][SLICE];
                res_q[k] <= nxt_res[k];
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                c_q[k]   <= st_c[k];
            end
            ovf1_q <= (SIGNED != 0) && o1_w;
            ovf2_q <= (SIGNED != 0) && o2_w;
        end
    end

    assign Out       = res_q[LAST];
    assign carryout1 = c1_q[LAST];
    assign carryout2 = c2_q[LAST];
    assign ovf1      = ovf1_q;
    assign ovf2      = ovf2_q;

    // The last stage's operand/sub copies have no consumer downstream.
    logic unused_last_stage;
    assign unused_last_stage = ^{sub_q[LAST], a_q[LAST], b_q[LAST], c_q[LAST]};

endmodule

// File: tb/tb_upe_pipeadd.sv
// Bench for upe_pipeadd: directed test-plan cases, backpressure, reset mid-flight and
// random traffic, all checked against an arithmetic reference model and a valid delay line.
module tb_upe_pipeadd;

    localparam int W  = 64;
    localparam int SL = 32;
    localparam int NS = W / SL;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_ready_u;
    logic [W-1:0] a, b, c;
    logic         sub, ci1, ci2;
    logic         out_valid, out_valid_u, out_ready;
    logic [W-1:0] out_s, out_u;
    logic         co1, co2, o1, o2;
    logic         co1_u, co2_u, o1_u, o2_u;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+3:0] exp_q[$];
    logic         vline[$];

    upe_pipeadd #(.WIDTH(W), .SLICE(SL), .SIGNED(1)) dut (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .C(c), .sub(sub), .carryin1(ci1), .carryin2(ci2),
        .out_valid(out_valid), .out_ready(out_ready), .Out(out_s),
        .carryout1(co1), .carryout2(co2), .ovf1(o1), .ovf2(o2)
    );

    upe_pipeadd #(.WIDTH(W), .SLICE(SL), .SIGNED(0)) dut_u (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .A(a), .B(b), .C(c), .sub(sub), .carryin1(ci1), .carryin2(ci2),
        .out_valid(out_valid_u), .out_ready(out_ready), .Out(out_u),
        .carryout1(co1_u), .carryout2(co2_u), .ovf1(o1_u), .ovf2(o2_u)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W+3:0] obs, input logic [W+3:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Packed result {Out, carryout1, carryout2, ovf1, ovf2}; overflow = true value out of range.
    function automatic logic [W+3:0] model(input logic [W-1:0] ma, mb, mc, input logic ms, m1, m2);
        logic [W:0]          s1, s2;
        logic signed [W+2:0] v1, v2;
        s1 = {1'b0, ma} + {1'b0, mb} + (W+1)'(m1);
        if (ms)
            s2 = {1'b0, s1[W-1:0]} + {1'b0, ~mc} + (W+1)'(!m2);
        else
            s2 = {1'b0, s1[W-1:0]} + {1'b0, mc} + (W+1)'(m2);
        v1 = (W+3)'($signed(ma)) + (W+3)'($signed(mb)) + (W+3)'(m1);
        if (ms)
            v2 = (W+3)'($signed(s1[W-1:0])) - (W+3)'($signed(mc)) - (W+3)'(m2);
        else
            v2 = (W+3)'($signed(s1[W-1:0])) + (W+3)'($signed(mc)) + (W+3)'(m2);
        return {s2[W-1:0], s1[W], s2[W],
                v1 != (W+3)'($signed(s1[W-1:0])),
                v2 != (W+3)'($signed(s2[W-1:0]))};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        vline.delete();
        for (int i = 0; i < NS; i++) vline.push_back(1'b0);
    endtask

    // One clock cycle: drive after the falling edge, check, then advance the model.
    task automatic cyc(input logic iv, input logic [W-1:0] ta, tb_, tc, input logic ts, t1, t2,
                       input logic ordy, output logic acc);
        logic         exp_ov, en;
        logic [W+3:0] e;
        @(negedge clk);
        in_valid = iv; a = ta; b = tb_; c = tc; sub = ts; ci1 = t1; ci2 = t2; out_ready = ordy;
        #1;
        exp_ov = vline[NS-1];
        en     = !exp_ov || ordy;
        check("out_valid", {{(W+3){1'b0}}, out_valid}, {{(W+3){1'b0}}, exp_ov});
        check("out_valid_unsigned", {{(W+3){1'b0}}, out_valid_u}, {{(W+3){1'b0}}, exp_ov});
        check("in_ready", {{(W+3){1'b0}}, in_ready}, {{(W+3){1'b0}}, en});
        if (exp_ov) begin
            e = exp_q[0];
            check("result", {out_s, co1, co2, o1, o2}, e);
            check("result_unsigned", {out_u, co1_u, co2_u, o1_u, o2_u}, {e[W+3:2], 2'b00});
        end
        if (exp_ov && ordy) void'(exp_q.pop_front());
        acc = iv && en;
        if (en) begin
            void'(vline.pop_back());
            vline.push_front(iv);
            if (iv) exp_q.push_back(model(ta, tb_, tc, ts, t1, t2));
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", {{(W+3){1'b0}}, out_valid}, '0);
        check("rst_result", {out_s, co1, co2, o1, o2}, '0);
        check("rst_result_unsigned", {out_u, co1_u, co2_u, o1_u, o2_u}, '0);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_model();
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 64'hFFFF_FFFF_FFFF_FFFF;
            1: return 64'h0;
            2: return 64'h7FFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic acc;
        int   sent, cycn;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c = '0;
        sub = 1'b0; ci1 = 1'b0; ci2 = 1'b0; out_ready = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        check("init_out_valid", {{(W+3){1'b0}}, out_valid}, '0);
        check("init_result", {out_s, co1, co2, o1, o2}, '0);
        #1 rst = 1'b0;

        // Test-plan directed cases, back to back with out_ready high.
        cyc(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h10, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 64'd10, 64'd5, 64'd20, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 64'd10, 64'd5, 64'd15, 1'b1, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b1, 1'b1, 1'b1, acc);
        repeat (3) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);

        // Backpressure: six transactions A=B=i, out_ready low for cycles 3..5.
        sent = 0; cycn = 0;
        while ((sent < 6 || exp_q.size() != 0) && cycn < 40) begin
            cyc(sent < 6, 64'(sent), 64'(sent), 64'd0, 1'b0, 1'b0, 1'b0,
                !(cycn >= 3 && cycn < 6), acc);
            if (acc) sent++;
            cycn++;
        end
        check("bp_complete", {{(W+3){1'b0}}, cycn < 40}, {{(W+3){1'b0}}, 1'b1});

        // Reset with two transactions in flight, then a fresh one.
        cyc(1'b1, 64'd100, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        cyc(1'b1, 64'd200, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        pulse_reset();
        cyc(1'b1, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("post_reset_sum", {out_s, 3'b000, out_valid}, {64'd7, 4'b0001});

        // Random traffic with random stalls and one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) pulse_reset();
            cyc($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), rnd_op(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3) != 0, acc);
        end
        repeat (NS + 3) cyc(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("drain_empty", (W+4)'(exp_q.size()), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
